// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: cache-side and memory-side pmem signals of the arbiter
interface pmem_arbiter_if #(
    parameter int s_line = 256,
    parameter int addr_w = 32
);
    logic              icache_pmem_read;
    logic [addr_w-1:0] icache_pmem_address;
    logic [s_line-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [addr_w-1:0] dcache_pmem_address;
    logic [s_line-1:0] dcache_pmem_wdata;
    logic              hold_arbiter;
    logic [s_line-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [addr_w-1:0] pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata, hold_arbiter,
        input  pmem_rdata, pmem_resp,
        output icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata, hold_arbiter,
        output pmem_rdata, pmem_resp,
        input  icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one pmem port between i-cache and d-cache; PMEM_ARB_RR_EN selects round-robin tie-break
module pmem_arbiter (
    input logic           clk,
    input logic           rst,
    pmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, D_HOLD} state_t;

    state_t state_q;
    logic   d_req;
    logic   d_win;
    logic   i_own;
    logic   d_own;

    assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;
    assign i_own = state_q == I_BUSY;
    assign d_own = state_q == D_BUSY;

`ifdef PMEM_ARB_RR_EN
    logic last_d_q;

    assign d_win = d_req & (~bus.icache_pmem_read | ~last_d_q);

    // remember which cache won the most recent grant out of IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_d_q <= 1'b0;
        else if (state_q == IDLE && (d_req || bus.icache_pmem_read)) last_d_q <= d_win;
    end
`else
    assign d_win = d_req;
`endif

    // ownership FSM; D_HOLD keeps the d-cache owning between write-back and refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else begin
            case (state_q)
                IDLE:    state_q <= d_win ? D_BUSY : (bus.icache_pmem_read ? I_BUSY : IDLE);
                I_BUSY:  state_q <= bus.pmem_resp ? IDLE : I_BUSY;
                D_BUSY:  state_q <= bus.pmem_resp ? (bus.hold_arbiter ? D_HOLD : IDLE) : D_BUSY;
                default: state_q <= d_req ? D_BUSY : (bus.hold_arbiter ? D_HOLD : IDLE);
            endcase
        end
    end

    // route the owner's request to memory and memory's answer back to the owner only
    always_comb begin
        bus.pmem_read         = i_own ? bus.icache_pmem_read : (d_own & bus.dcache_pmem_read & ~bus.dcache_pmem_write);
        bus.pmem_write        = d_own & bus.dcache_pmem_write;
        bus.pmem_address      = i_own ? bus.icache_pmem_address : (d_own ? bus.dcache_pmem_address : '0);
        bus.pmem_wdata        = d_own ? bus.dcache_pmem_wdata : '0;
        bus.icache_pmem_resp  = i_own & bus.pmem_resp;
        bus.icache_pmem_rdata = i_own ? bus.pmem_rdata : '0;
        bus.dcache_pmem_resp  = d_own & bus.pmem_resp;
        bus.dcache_pmem_rdata = d_own ? bus.pmem_rdata : '0;
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of grant order, routing, hold and reset behaviour
module tb_pmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pmem_arbiter_if bus ();

    pmem_arbiter u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] D1 = {8{32'hDEAD_0001}};
    localparam logic [255:0] WB = {8{32'h1234_5678}};

    initial begin
        bus.icache_pmem_read    = 1'b0;
        bus.icache_pmem_address = '0;
        bus.dcache_pmem_read    = 1'b0;
        bus.dcache_pmem_write   = 1'b0;
        bus.dcache_pmem_address = '0;
        bus.dcache_pmem_wdata   = '0;
        bus.hold_arbiter        = 1'b0;
        bus.pmem_rdata          = '0;
        bus.pmem_resp           = 1'b0;
        #1;
        chk("rst_read", bus.pmem_read, 0);
        chk("rst_write", bus.pmem_write, 0);
        chk("rst_addr", bus.pmem_address, 0);
        step();
        step();
        rst = 1'b0;

        // lone i-cache read
        step();
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'h0000_1040;
        #1 chk("t1_no_comb_grant", bus.pmem_read, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            #1 chk("t1_read_held", bus.pmem_read, 1);
        end
        chk("t1_addr", bus.pmem_address, 32'h0000_1040);
        step();
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = A5;
        #1;
        chk("t1_read_resp_cyc", bus.pmem_read, 1);
        chk("t1_iresp", bus.icache_pmem_resp, 1);
        chk("t1_irdata", bus.icache_pmem_rdata, A5);
        chk("t1_dresp", bus.dcache_pmem_resp, 0);
        chk("t1_drdata", bus.dcache_pmem_rdata, 0);
        step();
        bus.icache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        chk("t1_idle_read", bus.pmem_read, 0);
        chk("t1_idle_iresp", bus.icache_pmem_resp, 0);

        // simultaneous requests: d-cache first (last grant was i-cache)
        step();
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'h100;
        bus.dcache_pmem_read = 1'b1;
        bus.dcache_pmem_address = 32'h200;
        #1 chk("t2_no_comb_grant", bus.pmem_read, 0);
        step();
        #1;
        chk("t2_d_addr", bus.pmem_address, 32'h200);
        chk("t2_d_read", bus.pmem_read, 1);
        step();
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = D1;
        #1;
        chk("t2_dresp", bus.dcache_pmem_resp, 1);
        chk("t2_drdata", bus.dcache_pmem_rdata, D1);
        chk("t2_iresp_blocked", bus.icache_pmem_resp, 0);
        chk("t2_irdata_zero", bus.icache_pmem_rdata, 0);
        step();
        bus.dcache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;
        #1 chk("t2_gap", bus.pmem_read, 0);
        step();
        #1;
        chk("t2_i_addr", bus.pmem_address, 32'h100);
        chk("t2_i_read", bus.pmem_read, 1);
        bus.pmem_resp = 1'b1;
        #1 chk("t2_iresp", bus.icache_pmem_resp, 1);
        step();
        bus.icache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;

        // dirty eviction with hold, i-cache waiting
        step();
        bus.dcache_pmem_write = 1'b1;
        bus.dcache_pmem_address = 32'h300;
        bus.dcache_pmem_wdata = WB;
        bus.hold_arbiter = 1'b1;
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'h500;
        #1 chk("t3_no_comb_write", bus.pmem_write, 0);
        step();
        #1;
        chk("t3_write", bus.pmem_write, 1);
        chk("t3_read_off", bus.pmem_read, 0);
        chk("t3_addr", bus.pmem_address, 32'h300);
        chk("t3_wdata", bus.pmem_wdata, WB);
        step();
        bus.dcache_pmem_read = 1'b1;
        bus.pmem_resp = 1'b1;
        #1;
        chk("t3_both_rw_read", bus.pmem_read, 0);
        chk("t3_both_rw_write", bus.pmem_write, 1);
        chk("t3_dresp", bus.dcache_pmem_resp, 1);
        step();
        bus.dcache_pmem_write = 1'b0;
        bus.dcache_pmem_read = 1'b0;
        #1;
        chk("t3_hold_read", bus.pmem_read, 0);
        chk("t3_hold_addr", bus.pmem_address, 0);
        chk("t3_hold_iresp", bus.icache_pmem_resp, 0);
        chk("t3_hold_dresp", bus.dcache_pmem_resp, 0);
        bus.pmem_resp = 1'b0;
        bus.dcache_pmem_read = 1'b1;
        bus.dcache_pmem_address = 32'h400;
        step();
        #1;
        chk("t3_refill_addr", bus.pmem_address, 32'h400);
        chk("t3_refill_read", bus.pmem_read, 1);
        bus.hold_arbiter = 1'b0;
        bus.pmem_resp = 1'b1;
        #1 chk("t3_refill_dresp", bus.dcache_pmem_resp, 1);
        step();
        bus.dcache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;
        #1 chk("t3_gap", bus.pmem_read, 0);
        step();
        #1;
        chk("t3_i_addr", bus.pmem_address, 32'h500);
        chk("t3_i_read", bus.pmem_read, 1);
        bus.pmem_resp = 1'b1;
        step();
        bus.icache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;

        // hold dropped in D_HOLD with no d-cache request
        step();
        bus.dcache_pmem_read = 1'b1;
        bus.dcache_pmem_address = 32'h600;
        bus.hold_arbiter = 1'b1;
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'h700;
        step();
        #1 chk("t4_d_addr", bus.pmem_address, 32'h600);
        bus.pmem_resp = 1'b1;
        step();
        bus.dcache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.hold_arbiter = 1'b0;
        #1 chk("t4_hold_blocks_i", bus.pmem_read, 0);
        step();
        #1 chk("t4_idle_read", bus.pmem_read, 0);
        step();
        #1;
        chk("t4_i_addr", bus.pmem_address, 32'h700);
        chk("t4_i_read", bus.pmem_read, 1);
        bus.pmem_resp = 1'b1;
        step();
        bus.icache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;

        // tie right after a d-cache grant: fixed priority vs round-robin
        step();
        bus.dcache_pmem_read = 1'b1;
        bus.dcache_pmem_address = 32'h800;
        step();
        #1 chk("t5_d_addr", bus.pmem_address, 32'h800);
        bus.pmem_resp = 1'b1;
        step();
        bus.pmem_resp = 1'b0;
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'h900;
        bus.dcache_pmem_address = 32'hA00;
        step();
        bus.pmem_resp = 1'b1;
        #1;
`ifdef PMEM_ARB_RR_EN
        chk("t5_tie_addr", bus.pmem_address, 32'h900);
        chk("t5_tie_iresp", bus.icache_pmem_resp, 1);
`else
        chk("t5_tie_addr", bus.pmem_address, 32'hA00);
        chk("t5_tie_iresp", bus.icache_pmem_resp, 0);
`endif
        step();
        bus.icache_pmem_read = 1'b0;
        bus.dcache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;

        // spurious memory response in IDLE
        step();
        bus.pmem_resp = 1'b1;
        #1;
        chk("t6_iresp", bus.icache_pmem_resp, 0);
        chk("t6_dresp", bus.dcache_pmem_resp, 0);
        chk("t6_read", bus.pmem_read, 0);
        step();
        bus.pmem_resp = 1'b0;
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'hB00;
        #1 chk("t6_still_idle", bus.pmem_read, 0);
        step();
        #1 chk("t6_i_addr", bus.pmem_address, 32'hB00);
        bus.pmem_resp = 1'b1;
        step();
        bus.icache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;

        // reset in the middle of a d-cache transfer
        step();
        bus.dcache_pmem_write = 1'b1;
        bus.dcache_pmem_address = 32'hC00;
        bus.dcache_pmem_wdata = WB;
        bus.icache_pmem_read = 1'b1;
        bus.icache_pmem_address = 32'hD00;
        step();
        #1 chk("t7_write", bus.pmem_write, 1);
        rst = 1'b1;
        bus.pmem_resp = 1'b1;
        #1;
        chk("t7_rst_write", bus.pmem_write, 0);
        chk("t7_rst_addr", bus.pmem_address, 0);
        chk("t7_rst_wdata", bus.pmem_wdata, 0);
        chk("t7_rst_dresp", bus.dcache_pmem_resp, 0);
        step();
        bus.pmem_resp = 1'b0;
        bus.dcache_pmem_write = 1'b0;
        rst = 1'b0;
        #1 chk("t7_idle_after_rst", bus.pmem_read, 0);
        step();
        #1;
        chk("t7_i_read", bus.pmem_read, 1);
        chk("t7_i_addr", bus.pmem_address, 32'hD00);
        bus.pmem_resp = 1'b1;
        step();
        bus.icache_pmem_read = 1'b0;
        bus.pmem_resp = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
